// File: rtl/ifq_pkg.sv
// Shared widths, types and elaboration helpers for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned INSTR_WIDTH_DEF = 32;

  typedef logic [INSTR_WIDTH_DEF-1:0] instr_t;

  // Line pointer width including the wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned wsel_w(input int unsigned wpl);
    return $clog2(wpl);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ifq_word_sel.sv
// WPL:1 word mux: picks one instruction word out of a cache line, word 0 in the LSBs.
module ifq_word_sel
  import ifq_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic [LINE_WIDTH-1:0]                         line,
  input  logic [wsel_w(LINE_WIDTH/INSTR_WIDTH)-1:0]     sel,
  output logic [INSTR_WIDTH-1:0]                        word_c
);

  localparam int unsigned WPL = LINE_WIDTH / INSTR_WIDTH;

  logic [WPL-1:0][INSTR_WIDTH-1:0] words;

  assign words  = line;
  assign word_c = words[sel];

endmodule

// File: rtl/ifq_line_fifo.sv
// Instruction fetch queue: stores whole cache lines, hands out one word per pop,
// with flush/redirect that reloads the queue with the branch target line.
module ifq_line_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          wr_valid,
  input  logic [LINE_WIDTH-1:0]                         wr_line,
  output logic                                          wr_ready,
  input  logic                                          flush,
  input  logic [LINE_WIDTH-1:0]                         redir_line,
  input  logic [wsel_w(LINE_WIDTH/INSTR_WIDTH)-1:0]     redir_offset,
  input  logic                                          rd_ready,
  output logic                                          rd_valid,
  output logic [INSTR_WIDTH-1:0]                        rd_instr,
  output logic [ptr_w(DEPTH)-1:0]                       line_count,
  output logic                                          full,
  output logic                                          empty
);

  localparam int unsigned WPL    = LINE_WIDTH / INSTR_WIDTH;
  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned WSEL_W = wsel_w(WPL);
  localparam int unsigned IDX_W  = PTR_W - 1;

  // Parameter sanity checks at elaboration.
  if (LINE_WIDTH % INSTR_WIDTH != 0) begin : g_chk_width
    $error("ifq_line_fifo: LINE_WIDTH must be a multiple of INSTR_WIDTH");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
    $error("ifq_line_fifo: DEPTH must be a power of two >= 2");
  end
  if (!is_pow2(WPL) || WPL < 2) begin : g_chk_wpl
    $error("ifq_line_fifo: words per line must be a power of two >= 2");
  end

  logic [LINE_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wp_q;
  logic [PTR_W-1:0]      rp_q;
  logic [WSEL_W-1:0]     wsel_q;
  logic                  push;
  logic                  pop;
  logic                  line_done;

  assign empty      = (wp_q == rp_q);
  assign full       = (wp_q[IDX_W-1:0] == rp_q[IDX_W-1:0]) &&
                      (wp_q[PTR_W-1] != rp_q[PTR_W-1]);
  assign line_count = wp_q - rp_q;
  assign wr_ready   = !full && !flush;
  assign rd_valid   = !empty;

  assign push      = wr_valid && wr_ready;
  assign pop       = rd_valid && rd_ready && !flush;
  assign line_done = (wsel_q == WSEL_W'(WPL - 1));

  // Pointer update; flush reloads the queue with a single target line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      wsel_q <= '0;
    end else if (flush) begin
      wp_q   <= PTR_W'(1);
      rp_q   <= '0;
      wsel_q <= redir_offset;
    end else begin
      if (push) begin
        wp_q <= wp_q + PTR_W'(1);
      end
      if (pop) begin
        if (line_done) begin
          wsel_q <= '0;
          rp_q   <= rp_q + PTR_W'(1);
        end else begin
          wsel_q <= wsel_q + WSEL_W'(1);
        end
      end
    end
  end

  // Line storage; stale entries left by a flush are simply unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      mem_q[0] <= redir_line;
    end else if (push) begin
      mem_q[wp_q[IDX_W-1:0]] <= wr_line;
    end
  end

  ifq_word_sel #(
    .LINE_WIDTH  (LINE_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_word_sel (
    .line   (mem_q[rp_q[IDX_W-1:0]]),
    .sel    (wsel_q),
    .word_c (rd_instr)
  );

endmodule

// File: tb/tb_ifq_line_fifo.sv
// Directed, table-driven bench for ifq_line_fifo (128-bit lines, 32-bit words, depth 4).
module tb_ifq_line_fifo;

  logic         clk;
  logic         rst_n;
  logic         wr_valid;
  logic [127:0] wr_line;
  logic         wr_ready;
  logic         flush;
  logic [127:0] redir_line;
  logic [1:0]   redir_offset;
  logic         rd_ready;
  logic         rd_valid;
  logic [31:0]  rd_instr;
  logic [2:0]   line_count;
  logic         full;
  logic         empty;

  int n_vec;
  int n_bad;

  ifq_line_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_line      (wr_line),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .redir_line   (redir_line),
    .redir_offset (redir_offset),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_instr     (rd_instr),
    .line_count   (line_count),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wv;
    logic [127:0] wl;
    logic         fl;
    logic [127:0] rl;
    logic [1:0]   ro;
    logic         rr;
    logic         e_rv;
    logic [31:0]  e_ins;
    logic [2:0]   e_cnt;
    logic         e_full;
    logic         e_empty;
    logic         e_wrdy;
  } vec_t;

  vec_t tv[$];

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic add(input logic wv, input logic [127:0] wl, input logic fl,
                     input logic [127:0] rl, input logic [1:0] ro, input logic rr,
                     input logic rv, input logic [31:0] ins, input logic [2:0] cnt,
                     input logic fu, input logic em, input logic wrdy);
    vec_t v;
    v = '{wv, wl, fl, rl, ro, rr, rv, ins, cnt, fu, em, wrdy};
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  logic [127:0] l0, la, lb, lc, ld, lx, le, lg, lh, lr, lr1, lr2, lk, z;

  // Scoreboard state for the randomized wrap-around phase.
  logic [127:0] mq[$];
  int           mw;
  int           pushed;
  int           popped;
  logic [127:0] front;
  logic         acc_push;
  logic         acc_pop;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_line = '0;
    flush = 1'b0;
    redir_line = '0;
    redir_offset = '0;
    rd_ready = 1'b0;

    z   = '0;
    l0  = 128'h44443333_22221111_00000000_DEADBEEF;
    la  = mk(32'hA000_0000);
    lb  = mk(32'hB000_0000);
    lc  = mk(32'hC000_0000);
    ld  = mk(32'hD000_0000);
    lx  = mk(32'hF000_0000);
    le  = mk(32'hE000_0000);
    lg  = mk(32'h6000_0000);
    lh  = mk(32'h7777_0000);
    lr  = mk(32'h9000_0000);
    lr1 = mk(32'h1111_0000);
    lr2 = mk(32'h2222_0000);
    lk  = mk(32'h3333_0000);

    //   wv wl  fl rl   ro    rr   rv ins            cnt full empty wrdy
    add(0, z,  0, z,   2'd0, 0,   0, 32'h0,         3'd0, 0, 1, 1);  // reset state
    add(1, l0, 0, z,   2'd0, 0,   0, 32'h0,         3'd0, 0, 1, 1);  // push L0
    add(0, z,  0, z,   2'd0, 1,   1, 32'hDEADBEEF,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'h00000000,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'h22221111,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'h44443333,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 0,   0, 32'h0,         3'd0, 0, 1, 1);  // drained
    add(1, la, 0, z,   2'd0, 0,   0, 32'h0,         3'd0, 0, 1, 1);  // fill A..D
    add(1, lb, 0, z,   2'd0, 0,   1, 32'hA0000000,  3'd1, 0, 0, 1);
    add(1, lc, 0, z,   2'd0, 0,   1, 32'hA0000000,  3'd2, 0, 0, 1);
    add(1, ld, 0, z,   2'd0, 0,   1, 32'hA0000000,  3'd3, 0, 0, 1);
    add(1, lx, 0, z,   2'd0, 0,   1, 32'hA0000000,  3'd4, 1, 0, 0);  // 5th push refused
    add(1, lx, 0, z,   2'd0, 1,   1, 32'hA0000000,  3'd4, 1, 0, 0);
    add(0, z,  0, z,   2'd0, 0,   1, 32'hA0000001,  3'd4, 1, 0, 0);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hA0000001,  3'd4, 1, 0, 0);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hA0000002,  3'd4, 1, 0, 0);
    add(1, lx, 0, z,   2'd0, 1,   1, 32'hA0000003,  3'd4, 1, 0, 0);  // retire while full
    add(0, z,  0, z,   2'd0, 0,   1, 32'hB0000000,  3'd3, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hB0000000,  3'd3, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hB0000001,  3'd3, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hB0000002,  3'd3, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hB0000003,  3'd3, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hC0000000,  3'd2, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hC0000001,  3'd2, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'hC0000002,  3'd2, 0, 0, 1);
    add(1, le, 0, z,   2'd0, 1,   1, 32'hC0000003,  3'd2, 0, 0, 1);  // push + retire
    add(0, z,  0, z,   2'd0, 0,   1, 32'hD0000000,  3'd2, 0, 0, 1);
    add(1, lg, 0, z,   2'd0, 0,   1, 32'hD0000000,  3'd2, 0, 0, 1);
    add(1, lh, 1, lr,  2'd2, 1,   1, 32'hD0000000,  3'd3, 0, 0, 0);  // flush
    add(0, z,  0, z,   2'd0, 0,   1, 32'h90000002,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'h90000002,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 1,   1, 32'h90000003,  3'd1, 0, 0, 1);
    add(0, z,  0, z,   2'd0, 0,   0, 32'hE0000000,  3'd0, 0, 1, 1);  // flush-cycle line absent
    add(0, z,  1, lr1, 2'd1, 0,   0, 32'hE0000000,  3'd0, 0, 1, 0);  // back-to-back flush
    add(0, z,  1, lr2, 2'd3, 0,   1, 32'h11110001,  3'd1, 0, 0, 0);
    add(0, z,  0, z,   2'd0, 0,   1, 32'h22220003,  3'd1, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tv[i]) begin
      wr_valid     = tv[i].wv;
      wr_line      = tv[i].wl;
      flush        = tv[i].fl;
      redir_line   = tv[i].rl;
      redir_offset = tv[i].ro;
      rd_ready     = tv[i].rr;
      @(negedge clk);
      n_vec++;
      if (rd_valid !== tv[i].e_rv || rd_instr !== tv[i].e_ins || line_count !== tv[i].e_cnt ||
          full !== tv[i].e_full || empty !== tv[i].e_empty || wr_ready !== tv[i].e_wrdy) begin
        n_bad++;
        $display("FAIL vec%0d: got rv=%0b instr=%h cnt=%0d full=%0b empty=%0b wrdy=%0b, expected rv=%0b instr=%h cnt=%0d full=%0b empty=%0b wrdy=%0b",
                 i, rd_valid, rd_instr, line_count, full, empty, wr_ready,
                 tv[i].e_rv, tv[i].e_ins, tv[i].e_cnt, tv[i].e_full, tv[i].e_empty, tv[i].e_wrdy);
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    flush = 1'b0;
    rd_ready = 1'b0;

    // Reset asserted mid-stream with two lines queued.
    wr_valid = 1'b1;
    wr_line  = lk;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_count", 32'(line_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(line_count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_instr", rd_instr, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic across several pointer wraps against a line scoreboard.
    mw = 0;
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 2000 && popped < 40; cyc++) begin
      wr_valid = (pushed < 10) && ($urandom_range(0, 1) == 1);
      wr_line  = mk(32'h5000_0000 + (32'(pushed) << 8));
      rd_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      chk("wrap_count", 32'(line_count), 32'(mq.size()));
      chk("wrap_wr_ready", 32'(wr_ready), 32'(mq.size() < 4));
      chk("wrap_full_and_empty", 32'(full && empty), 32'd0);
      acc_pop  = rd_ready && (mq.size() > 0);
      acc_push = wr_valid && (mq.size() < 4);
      if (acc_pop) begin
        front = mq[0];
        chk("wrap_rd_instr", rd_instr, front[mw*32 +: 32]);
        popped++;
        if (mw == 3) begin
          mw = 0;
          void'(mq.pop_front());
        end else begin
          mw++;
        end
      end
      if (acc_push) begin
        mq.push_back(wr_line);
        pushed++;
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("wrap_words_drained", 32'(popped), 32'd40);
    @(negedge clk);
    chk("wrap_final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
